// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle arithmetic/logic/shift, iterative shift-add multiply and
// restoring divide, with registered valid/ready handshakes on both sides.
module alu_seq_core #(
    parameter int unsigned N      = 32,
    parameter bit          DIV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    input  logic         signed_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         carry_out,
    output logic         zero,
    output logic         overflow,
    output logic         div_by_zero,
    output logic         err
);

    localparam int unsigned LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    logic [1:0]    state_q;
    logic [LW-1:0] cnt_q;
    logic          is_div_q, neg_q, rneg_q, sgn_q, dz_q, dovf_q;
    logic [N-1:0]  a_q, mb_q, hi_q, lo_q;

    logic          accept, is_iter, a_neg, b_neg;
    logic [N-1:0]  mag_a, mag_b;
    logic [LW-1:0] shamt;
    logic [N:0]    add_sum, sub_dif;

    logic [N-1:0]  sc_res;
    logic          sc_carry, sc_ovf, sc_err;

    logic [N:0]    mul_sum, div_sh, div_diff;
    logic [N-1:0]  mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;

    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quo, rem, fx_res, fx_hi;
    logic           fx_ovf;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_iter  = (opcode == OP_MUL) || (DIV_EN && (opcode == OP_DIV));

    assign a_neg = signed_op & a[N-1];
    assign b_neg = signed_op & b[N-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    assign shamt   = b[LW-1:0];
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res   = add_sum[N-1:0];
                sc_carry = add_sum[N];
                sc_ovf   = (a[N-1] == b[N-1]) && (add_sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // Direct subtraction: bit N is already the borrow (a < b unsigned).
                sc_res   = sub_dif[N-1:0];
                sc_carry = sub_dif[N];
                sc_ovf   = (a[N-1] != b[N-1]) && (sub_dif[N-1] != a[N-1]);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SLL: sc_res = a << shamt;
            OP_SRL: sc_res = a >> shamt;
            OP_SRA: sc_res = $signed(a) >>> shamt;
            OP_MUL: sc_res = '0;
            OP_DIV: sc_err = !DIV_EN;
            default: sc_err = 1'b1;
        endcase
    end

    // One shift-add multiply step: {hi, lo} holds partial product and remaining multiplier.
    assign mul_sum   = {1'b0, hi_q} + {1'b0, mb_q & {N{lo_q[0]}}};
    assign mul_hi_nx = mul_sum[N:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[N-1:1]};

    // One restoring divide step: hi is the remainder, lo shifts dividend out / quotient in.
    // shifted < 2*divisor, so the sign bit of the trial difference is the restore decision.
    assign div_sh    = {hi_q, lo_q[N-1]};
    assign div_diff  = div_sh - {1'b0, mb_q};
    assign div_hi_nx = div_diff[N] ? div_sh[N-1:0] : div_diff[N-1:0];
    assign div_lo_nx = {lo_q[N-2:0], !div_diff[N]};

    assign prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo    = neg_q ? -lo_q : lo_q;
    assign rem    = rneg_q ? -hi_q : hi_q;

    always_comb begin
        fx_res = '0;
        fx_hi  = '0;
        fx_ovf = 1'b0;
        if (!is_div_q) begin
            fx_res = prod_s[N-1:0];
            fx_hi  = prod_s[2*N-1:N];
            fx_ovf = sgn_q ? (prod_s[2*N-1:N] != {N{prod_s[N-1]}})
                           : (prod_s[2*N-1:N] != '0);
        end else if (dz_q) begin
            fx_res = '1;
            fx_hi  = a_q;
        end else if (dovf_q) begin
            fx_res = {1'b1, {(N-1){1'b0}}};
            fx_ovf = 1'b1;
        end else begin
            fx_res = quo;
            fx_hi  = rem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            sgn_q       <= 1'b0;
            dz_q        <= 1'b0;
            dovf_q      <= 1'b0;
            a_q         <= '0;
            mb_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept && is_iter) begin
                        state_q  <= CALC;
                        cnt_q    <= '0;
                        is_div_q <= (opcode == OP_DIV);
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        sgn_q    <= signed_op;
                        dz_q     <= (b == '0);
                        dovf_q   <= signed_op && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
                        a_q      <= a;
                        mb_q     <= mag_b;
                        hi_q     <= '0;
                        lo_q     <= mag_a;
                    end else if (accept) begin
                        // Illegal opcodes report every flag except err as 0, zero included.
                        out_valid   <= 1'b1;
                        result      <= sc_res;
                        result_hi   <= '0;
                        carry_out   <= sc_carry;
                        zero        <= (sc_res == '0) && !sc_err;
                        overflow    <= sc_ovf;
                        div_by_zero <= 1'b0;
                        err         <= sc_err;
                    end
                end
                CALC: begin
                    hi_q  <= is_div_q ? div_hi_nx : mul_hi_nx;
                    lo_q  <= is_div_q ? div_lo_nx : mul_lo_nx;
                    cnt_q <= cnt_q + LW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q     <= IDLE;
                    out_valid   <= 1'b1;
                    result      <= fx_res;
                    result_hi   <= fx_hi;
                    carry_out   <= 1'b0;
                    zero        <= (fx_res == '0);
                    overflow    <= fx_ovf;
                    div_by_zero <= is_div_q && dz_q;
                    err         <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed vectors push expected results, a monitor
// pops and compares on every output handshake.
module tb_alu_seq_core;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, signed_op, out_valid, out_ready;
    logic         carry_out, zero, overflow, div_by_zero, err;
    logic [N-1:0] a, b, result, result_hi;
    logic [3:0]   opcode;

    // fl = {carry_out, zero, overflow, div_by_zero, err}
    typedef struct {
        string        tag;
        logic [N-1:0] res;
        logic [N-1:0] hi;
        logic [4:0]   fl;
    } exp_t;

    exp_t sb_q[$];
    int   nvec = 0;
    int   nfail = 0;

    alu_seq_core #(.N(N), .DIV_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .signed_op  (signed_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .carry_out  (carry_out),
        .zero       (zero),
        .overflow   (overflow),
        .div_by_zero(div_by_zero),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Monitor: a result is consumed at the posedge following a negedge with valid && ready.
    initial begin
        exp_t       e;
        logic [4:0] fl;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                fl = {carry_out, zero, overflow, div_by_zero, err};
                nvec++;
                if (sb_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_result: got res=%h hi=%h, required no output",
                             result, result_hi);
                end else begin
                    e = sb_q.pop_front();
                    if (result !== e.res || result_hi !== e.hi || fl !== e.fl) begin
                        nfail++;
                        $display("FAIL %s: got res=%h hi=%h flags=%b, required res=%h hi=%h flags=%b",
                                 e.tag, result, result_hi, fl, e.res, e.hi, e.fl);
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input string tag, input logic [N-1:0] r, input logic [N-1:0] h,
                                input logic [4:0] fl);
        exp_t e;
        e.tag = tag;
        e.res = r;
        e.hi  = h;
        e.fl  = fl;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic s, input bit push, input exp_t e);
        int t;
        in_valid  = 1'b1;
        opcode    = op;
        a         = va;
        b         = vb;
        signed_op = s;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL %s_accept: got in_ready=0 for 200 cycles, required 1", e.tag);
            in_valid = 1'b0;
            return;
        end
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [3:0] opc, input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic s, input exp_t e);
        issue(opc, va, vb, s, 1'b1, e);
    endtask

    // Counts negedges after the accept edge until out_valid is seen.
    task automatic lat(input string name, input int exp_lat);
        int n;
        int busy_ready;
        n = 0;
        busy_ready = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) busy_ready++;
        end while (!out_valid && n < 100);
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        if (exp_lat > 1) check({name, "_in_ready_busy"}, 64'(busy_ready), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({name, "_drain_pending"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        exp_t dummy;
        dummy = mk("none", '0, '0, 5'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        opcode = '0;
        signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_result", {result, result_hi}, 64'd0);
        check("reset_flags", 64'({carry_out, zero, overflow, div_by_zero, err}), 64'd0);

        // Single-cycle ops, back-to-back after the first.
        op(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b0, mk("add_ovf", 32'h8000_0000, '0, 5'b00100));
        lat("add_ovf", 1);
        op(4'b0001, 32'h1, 32'h2, 1'b0, mk("sub_borrow", 32'hFFFF_FFFF, '0, 5'b10000));
        op(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b1, mk("add_carry_zero", '0, '0, 5'b11000));
        op(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, mk("and", 32'hF000_F000, '0, 5'b0));
        op(4'b0011, 32'h0F0F_0000, 32'h0000_00FF, 1'b0, mk("or", 32'h0F0F_00FF, '0, 5'b0));
        op(4'b0100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, mk("xor_zero", '0, '0, 5'b01000));
        op(4'b0101, 32'h1, 32'h24, 1'b0, mk("sll_amt_mask", 32'h10, '0, 5'b0));
        op(4'b0110, 32'h8000_0000, 32'd31, 1'b1, mk("srl", 32'h1, '0, 5'b0));
        op(4'b0111, 32'h8000_0000, 32'd4, 1'b0, mk("sra", 32'hF800_0000, '0, 5'b0));
        op(4'b0001, 32'h8000_0000, 32'h1, 1'b0, mk("sub_ovf", 32'h7FFF_FFFF, '0, 5'b00100));
        op(4'b1100, 32'h5, 32'h6, 1'b0, mk("illegal", '0, '0, 5'b00001));

        // Multiply.
        op(4'b1000, 32'hFFFF_FFFD, 32'd7, 1'b1,
           mk("smul_neg", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 5'b0));
        lat("smul_neg", 34);
        op(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b0, mk("umul_ovf", 32'hFFFF_FFFE, 32'h1, 5'b00100));
        op(4'b1000, 32'h0001_0000, 32'h0001_0000, 1'b1, mk("smul_ovf", '0, 32'h1, 5'b01100));
        op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk("smul_m1m1", 32'h1, '0, 5'b0));

        // Divide.
        op(4'b1001, 32'd7, 32'd0, 1'b0, mk("udiv_by0", 32'hFFFF_FFFF, 32'd7, 5'b00010));
        op(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
           mk("sdiv_min_m1", 32'h8000_0000, '0, 5'b00100));
        op(4'b1001, 32'hFFFF_FFF9, 32'd2, 1'b1,
           mk("sdiv_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b0));
        op(4'b1001, 32'd100, 32'd7, 1'b0, mk("udiv_100_7", 32'd14, 32'd2, 5'b0));
        op(4'b1001, 32'd7, 32'hFFFF_FFFE, 1'b1, mk("sdiv_7_m2", 32'hFFFF_FFFD, 32'd1, 5'b0));
        op(4'b1001, 32'hFFFF_FFFF, 32'd10, 1'b0, mk("udiv_max_10", 32'h1999_9999, 32'd5, 5'b0));
        op(4'b1001, 32'd0, 32'd5, 1'b1, mk("sdiv_zero", '0, '0, 5'b01000));
        drain("main");

        // Consumer stall: result must hold and new requests must be ignored.
        out_ready = 1'b0;
        op(4'b0100, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, mk("stall_xor", 32'hEDCB_A987, '0, 5'b0));
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                in_valid = 1'b1;
                opcode = 4'b0000;
                a = 32'h11;
                b = 32'h22;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("stall_hold", {30'b0, out_valid, in_ready, result},
                  {30'b0, 1'b1, 1'b0, 32'hEDCB_A987});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("stall");

        // Reset in CALC cycle 10 of a multiply discards it.
        issue(4'b1000, 32'd3, 32'd7, 1'b0, 1'b0, dummy);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_reset_out_valid", 64'(out_valid), 64'd0);
        check("midop_reset_in_ready", 64'(in_ready), 64'd1);
        op(4'b0000, 32'd2, 32'd3, 1'b0, mk("add_after_reset", 32'd5, '0, 5'b0));
        lat("add_after_reset", 1);
        repeat (40) @(posedge clk);
        #1;
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
